// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, opcodes and control-word bit map for the execution sequencer
package seq_pkg;

    localparam int CTRL_W = 22;

    // Control word bit indices, LSB first
    localparam int B_PCLADLOA = 0;
    localparam int B_PCHADHOA = 1;
    localparam int B_PCLINC   = 2;
    localparam int B_ABLWA    = 3;
    localparam int B_ABHWA    = 4;
    localparam int B_DLWA     = 5;
    localparam int B_DLDBOA   = 6;
    localparam int B_DLADLOA  = 7;
    localparam int B_ADHZERO  = 8;
    localparam int B_DBSB     = 9;
    localparam int B_ACCWA    = 10;
    localparam int B_ACCSBOA  = 11;
    localparam int B_ACCDBOA  = 12;
    localparam int B_PREDBWA  = 13;
    localparam int B_PRESBWA  = 14;
    localparam int B_SUMS     = 15;
    localparam int B_DECEN    = 16;
    localparam int B_ALUSBOA  = 17;
    localparam int B_SALUWA   = 18;
    localparam int B_DORWA    = 19;
    localparam int B_DOROA    = 20;
    localparam int B_CIN      = 21;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_ADC_ZP  = 8'h65;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    // T-states use their own number as encoding so tstate is a direct view; RST sits at 7
    typedef enum logic [2:0] {
        S_T0  = 3'd0,
        S_T1  = 3'd1,
        S_T2  = 3'd2,
        S_T3  = 3'd3,
        S_T4  = 3'd4,
        S_T5  = 3'd5,
        S_RST = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_LD  = 2'd1,
        CLS_ADC = 2'd2,
        CLS_ST  = 2'd3
    } op_class_e;

    function automatic logic [CTRL_W-1:0] m(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    // PC onto the address bus with increment: opcode and immediate operand fetch
    function automatic logic [CTRL_W-1:0] fetch_m();
        return m(B_PCLADLOA) | m(B_PCHADHOA) | m(B_ABLWA) | m(B_ABHWA) | m(B_PCLINC);
    endfunction

    // Operand byte as low address, adh forced to page zero
    function automatic logic [CTRL_W-1:0] zp_addr_m();
        return m(B_DLADLOA) | m(B_ADHZERO) | m(B_ABLWA) | m(B_ABHWA);
    endfunction

    function automatic logic [CTRL_W-1:0] load_m();
        return m(B_DLDBOA) | m(B_DBSB) | m(B_ACCWA);
    endfunction

    // ADC phases: 0 load prealu operands, 1 add (cin is merged later), 2 write back
    function automatic logic [CTRL_W-1:0] adc_m(input logic [1:0] ph);
        case (ph)
            2'd0:    return m(B_DLDBOA) | m(B_PREDBWA) | m(B_ACCSBOA) | m(B_PRESBWA);
            2'd1:    return m(B_SUMS) | m(B_DECEN);
            2'd2:    return m(B_ALUSBOA) | m(B_ACCWA) | m(B_SALUWA);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - sequencer-to-board control bundle
interface exec_sequencer_if #(
    parameter int CTRL_W = 22
);
    logic [7:0]        opin;
    logic              carry;
    logic              rdy;
    logic [CTRL_W-1:0] ctrl;
    logic              sync;
    logic              rw;
    logic [2:0]        tstate;
    logic [7:0]        opcode;

    modport master (
        output opin, carry, rdy,
        input  ctrl, sync, rw, tstate, opcode
    );

    modport slave (
        input  opin, carry, rdy,
        output ctrl, sync, rw, tstate, opcode
    );
endinterface

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - opcode to addressing mode, operation class and final T-state
module seq_decode
    import seq_pkg::*;
(
    input  logic [7:0] i_opcode,
    output op_class_e  o_cls,
    output logic       o_is_zp,
    output state_e     o_last
);

    // Undefined opcodes fall through as NOP so the sequencer always returns to T0
    always_comb begin
        o_cls   = CLS_NOP;
        o_is_zp = 1'b0;
        o_last  = S_T1;
        case (i_opcode)
            OP_LDA_IMM: begin o_cls = CLS_LD;  o_last = S_T2; end
            OP_ADC_IMM: begin o_cls = CLS_ADC; o_last = S_T4; end
            OP_LDA_ZP:  begin o_cls = CLS_LD;  o_is_zp = 1'b1; o_last = S_T3; end
            OP_ADC_ZP:  begin o_cls = CLS_ADC; o_is_zp = 1'b1; o_last = S_T5; end
            OP_STA_ZP:  begin o_cls = CLS_ST;  o_is_zp = 1'b1; o_last = S_T3; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - hardwired T-state sequencer driving the datapath strobes
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int CTRL_W = 22
) (
    input logic             clk,
    input logic             clr,
    exec_sequencer_if.slave bus
);

    state_e            r_state;
    state_e            w_next;
    logic [7:0]        r_opcode;
    op_class_e         w_cls;
    logic              w_zp;
    state_e            w_last;
    logic [CTRL_W-1:0] w_raw;
    logic              w_sync;
    logic              w_rw;

    seq_decode u_decode (
        .i_opcode (r_opcode),
        .o_cls    (w_cls),
        .o_is_zp  (w_zp),
        .o_last   (w_last)
    );

    // State and instruction register; a stall freezes both, including the T0 opcode load
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_RST;
            r_opcode <= OP_NOP;
        end else if (bus.rdy) begin
            r_state <= w_next;
            if (r_state == S_T0)
                r_opcode <= bus.opin;
        end
    end

    // Next state: walk T-states up to the opcode's last one; anything unexpected lands in T0
    always_comb begin
        w_next = S_T0;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0:  w_next = S_T1;
            S_T1, S_T2, S_T3, S_T4:
                w_next = (r_state >= w_last) ? S_T0 : state_e'(r_state + 3'd1);
            default: w_next = S_T0;
        endcase
    end

    // Strobe decode from registered state and opcode; cin only rides along with sums
    always_comb begin
        w_raw  = '0;
        w_sync = 1'b0;
        w_rw   = 1'b1;
        case (r_state)
            S_T0: begin
                w_raw  = fetch_m();
                w_sync = 1'b1;
            end
            S_T1: if (w_cls != CLS_NOP) w_raw = fetch_m() | m(B_DLWA);
            S_T2: begin
                if (w_zp)
                    w_raw = zp_addr_m() | ((w_cls == CLS_ST) ? (m(B_ACCDBOA) | m(B_DORWA)) : m(B_DLWA));
                else if (w_cls == CLS_LD)
                    w_raw = load_m();
                else if (w_cls == CLS_ADC)
                    w_raw = adc_m(2'd0);
            end
            S_T3: begin
                if (w_zp) begin
                    case (w_cls)
                        CLS_LD:  w_raw = load_m();
                        CLS_ADC: w_raw = adc_m(2'd0);
                        CLS_ST:  begin w_raw = m(B_DOROA); w_rw = 1'b0; end
                        default: ;
                    endcase
                end else if (w_cls == CLS_ADC) begin
                    w_raw = adc_m(2'd1);
                end
            end
            S_T4: if (w_cls == CLS_ADC) w_raw = adc_m(w_zp ? 2'd1 : 2'd2);
            S_T5: if (w_cls == CLS_ADC && w_zp) w_raw = adc_m(2'd2);
            default: ;
        endcase
        w_raw[B_CIN] = w_raw[B_SUMS] & bus.carry;
    end

    assign bus.ctrl   = bus.rdy ? w_raw : '0;
    assign bus.sync   = bus.rdy & w_sync;
    assign bus.rw     = ~bus.rdy | w_rw;
    assign bus.tstate = (r_state > S_T5) ? 3'd0 : r_state;
    assign bus.opcode = r_opcode;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer
module tb_exec_sequencer;

    localparam int PCLADLOA = 0,  PCHADHOA = 1,  PCLINC = 2,   ABLWA = 3,   ABHWA = 4;
    localparam int DLWA = 5,      DLDBOA = 6,    DLADLOA = 7,  ADHZERO = 8, DBSB = 9;
    localparam int ACCWA = 10,    ACCSBOA = 11,  ACCDBOA = 12, PREDBWA = 13, PRESBWA = 14;
    localparam int SUMS = 15,     DECEN = 16,    ALUSBOA = 17, SALUWA = 18, DORWA = 19;
    localparam int DOROA = 20,    CIN = 21;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    exec_sequencer_if bus ();

    exec_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic        rdy;
        logic [21:0] ctrl;
        logic        sync;
        logic        rw;
        logic [2:0]  ts;
        logic [7:0]  opc;
    } cyc_t;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  opnd;
        logic        carry;
        int          stall_at;
        int          stall_n;
        int          chk;
        logic [7:0]  exp_val;
        logic [15:0] exp_addr;
    } vec_t;

    cyc_t sbq[$];
    vec_t vt[11];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] pc, abus, wr_addr;
    logic [7:0]  dl, acc, pre_a, pre_b, dor, wr_data, prev_op;
    logic [8:0]  alu;
    logic [7:0]  mem[256];

    function automatic logic [21:0] b(input int i);
        return 22'd1 << i;
    endfunction

    function automatic logic [21:0] exp_ctrl(input logic [7:0] op, input int t, input logic c);
        logic [21:0] f, zp, ld, a0, a1, a2;
        f  = b(PCLADLOA) | b(PCHADHOA) | b(ABLWA) | b(ABHWA) | b(PCLINC);
        zp = b(DLADLOA) | b(ADHZERO) | b(ABLWA) | b(ABHWA);
        ld = b(DLDBOA) | b(DBSB) | b(ACCWA);
        a0 = b(DLDBOA) | b(PREDBWA) | b(ACCSBOA) | b(PRESBWA);
        a1 = b(SUMS) | b(DECEN) | (c ? b(CIN) : 22'd0);
        a2 = b(ALUSBOA) | b(ACCWA) | b(SALUWA);
        if (t == 0) return f;
        case (op)
            8'hA9: case (t) 1: return f | b(DLWA); 2: return ld; default: return 22'd0; endcase
            8'h69: case (t) 1: return f | b(DLWA); 2: return a0; 3: return a1; 4: return a2;
                            default: return 22'd0; endcase
            8'hA5: case (t) 1: return f | b(DLWA); 2: return zp | b(DLWA); 3: return ld;
                            default: return 22'd0; endcase
            8'h65: case (t) 1: return f | b(DLWA); 2: return zp | b(DLWA); 3: return a0;
                            4: return a1; 5: return a2; default: return 22'd0; endcase
            8'h85: case (t) 1: return f | b(DLWA); 2: return zp | b(ACCDBOA) | b(DORWA);
                            3: return b(DOROA); default: return 22'd0; endcase
            default: return 22'd0;
        endcase
    endfunction

    function automatic int exp_len(input logic [7:0] op);
        case (op)
            8'hA9: return 3;
            8'h69: return 5;
            8'hA5: return 4;
            8'h65: return 6;
            8'h85: return 4;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Board datapath reacting to the strobes of the current cycle
    task automatic board_step();
        logic [21:0] c;
        c = bus.ctrl;
        if (c[ABLWA] && c[ABHWA]) begin
            if (c[PCLADLOA] && c[PCHADHOA]) abus = pc;
            else if (c[DLADLOA] && c[ADHZERO]) abus = {8'h00, dl};
        end
        if (c[DLWA]) dl = mem[abus[7:0]];
        if (c[PCLINC]) pc = pc + 16'd1;
        if (c[DLDBOA] && c[DBSB] && c[ACCWA]) acc = dl;
        if (c[DLDBOA] && c[PREDBWA]) pre_a = dl;
        if (c[ACCSBOA] && c[PRESBWA]) pre_b = acc;
        if (c[SUMS]) alu = {1'b0, pre_a} + {1'b0, pre_b} + {8'd0, c[CIN]};
        if (c[ALUSBOA] && c[ACCWA] && c[SALUWA]) acc = alu[7:0];
        if (c[ACCDBOA] && c[DORWA]) dor = acc;
        if (c[DOROA] && !bus.rw) begin
            mem[abus[7:0]] = dor;
            wr_addr = abus;
            wr_data = dor;
        end
    endtask

    // Push the expected trace for one instruction, then drive and compare cycle by cycle
    task automatic run_instr(input vec_t v);
        cyc_t r;
        int   len;
        len = exp_len(v.op);
        mem[pc[7:0] + 8'd1] = v.opnd;
        for (int t = 0; t < len; t++) begin
            if (t == v.stall_at)
                for (int s = 0; s < v.stall_n; s++)
                    sbq.push_back('{1'b0, 22'd0, 1'b0, 1'b1, 3'(t), (t == 0) ? prev_op : v.op});
            sbq.push_back('{1'b1, exp_ctrl(v.op, t, v.carry), (t == 0), !(v.op == 8'h85 && t == 3),
                            3'(t), (t == 0) ? prev_op : v.op});
        end
        prev_op = v.op;
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            bus.rdy   = r.rdy;
            bus.opin  = v.op;
            bus.carry = v.carry;
            #1;
            check($sformatf("op%h t%0d ctrl", v.op, r.ts), 32'(bus.ctrl), 32'(r.ctrl));
            check($sformatf("op%h t%0d sync", v.op, r.ts), 32'(bus.sync), 32'(r.sync));
            check($sformatf("op%h t%0d rw", v.op, r.ts), 32'(bus.rw), 32'(r.rw));
            check($sformatf("op%h t%0d tstate", v.op, r.ts), 32'(bus.tstate), 32'(r.ts));
            check($sformatf("op%h t%0d opcode", v.op, r.ts), 32'(bus.opcode), 32'(r.opc));
            if (r.rdy) board_step();
            @(posedge clk);
            #1;
        end
        bus.rdy = 1'b1;
        if (v.chk == 1)
            check($sformatf("op%h acc", v.op), 32'(acc), 32'(v.exp_val));
        if (v.chk == 2) begin
            check($sformatf("op%h store addr", v.op), 32'(wr_addr), 32'(v.exp_addr));
            check($sformatf("op%h store data", v.op), 32'(wr_data), 32'(v.exp_val));
        end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        //           op     opnd   cy    stall_at n  chk val    addr
        vt[0]  = '{8'hA9, 8'h05, 1'b0, -1, 0, 1, 8'h05, 16'h0000};
        vt[1]  = '{8'h69, 8'h0F, 1'b0, -1, 0, 1, 8'h14, 16'h0000};
        vt[2]  = '{8'h85, 8'h10, 1'b0, -1, 0, 2, 8'h14, 16'h0010};
        vt[3]  = '{8'hEA, 8'h00, 1'b0, -1, 0, 0, 8'h00, 16'h0000};
        vt[4]  = '{8'hFF, 8'h00, 1'b0, -1, 0, 0, 8'h00, 16'h0000};
        vt[5]  = '{8'hA9, 8'h33, 1'b0, -1, 0, 1, 8'h33, 16'h0000};
        vt[6]  = '{8'hA5, 8'h10, 1'b0, -1, 0, 1, 8'h14, 16'h0000};
        vt[7]  = '{8'h65, 8'h10, 1'b1, -1, 0, 1, 8'h29, 16'h0000};
        vt[8]  = '{8'h69, 8'hFF, 1'b1,  0, 2, 1, 8'h29, 16'h0000};
        vt[9]  = '{8'h65, 8'h10, 1'b0,  4, 3, 1, 8'h3D, 16'h0000};
        vt[10] = '{8'hA5, 8'h10, 1'b0,  1, 2, 1, 8'h14, 16'h0000};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        pc = 16'h0040; abus = 16'h0; wr_addr = 16'h0; dl = 8'h0; acc = 8'h0;
        pre_a = 8'h0; pre_b = 8'h0; dor = 8'h0; wr_data = 8'h0; alu = 9'h0;
        prev_op = 8'hEA;
        bus.opin = 8'hEA; bus.carry = 1'b0; bus.rdy = 1'b1;
        clr = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset ctrl", 32'(bus.ctrl), 32'd0);
        check("reset sync", 32'(bus.sync), 32'd0);
        check("reset rw", 32'(bus.rw), 32'd1);
        check("reset tstate", 32'(bus.tstate), 32'd0);
        check("reset opcode", 32'(bus.opcode), 32'hEA);
        clr = 1'b0;
        #1;
        check("rst cycle ctrl", 32'(bus.ctrl), 32'd0);
        check("rst cycle sync", 32'(bus.sync), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_instr(vt[i]);

        // Abort ADC zp in T3 with clr and watch outputs fall back before any clock
        bus.opin = 8'h65; bus.carry = 1'b1; bus.rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort pre tstate", 32'(bus.tstate), 32'd3);
        check("abort pre ctrl", 32'(bus.ctrl), 32'(exp_ctrl(8'h65, 3, 1'b1)));
        #2 clr = 1'b1;
        #1;
        check("abort ctrl", 32'(bus.ctrl), 32'd0);
        check("abort rw", 32'(bus.rw), 32'd1);
        check("abort sync", 32'(bus.sync), 32'd0);
        check("abort tstate", 32'(bus.tstate), 32'd0);
        check("abort opcode", 32'(bus.opcode), 32'hEA);
        @(posedge clk);
        #1;
        check("abort held ctrl", 32'(bus.ctrl), 32'd0);
        clr = 1'b0;
        #1;
        check("abort rst sync", 32'(bus.sync), 32'd0);
        check("abort rst ctrl", 32'(bus.ctrl), 32'd0);
        @(posedge clk);
        #1;
        prev_op = 8'hEA;
        run_instr('{8'hA9, 8'h5A, 1'b0, -1, 0, 1, 8'h5A, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
